// File: rtl/timer_arbiter.sv
// timer_arbiter: one shared millisecond countdown timer, handed out round-robin to NUM_REQ
// requesters. An internal prescaler turns the system clock into a tick. The granted
// requester's duration is counted down in ticks, and then that requester gets a one-cycle
// done pulse.
//
// Optional build macro: TIMER_ARBITER_ABORT_EN. When it is defined, the owner dropping its
// request during RUN aborts the run with no done pulse. When it is undefined, a request
// drop during RUN is ignored.
//
// Ports:
//   clk    in   system clock (1 MHz nominal); everything changes on the rising edge
//   reset  in   synchronous, active-high reset
//   req    in   [NUM_REQ] request levels, held until done
//   dur    in   [NUM_REQ*DUR_W] packed durations in ticks; requester i uses [i*DUR_W +: DUR_W]
//   grant  out  [NUM_REQ] one-hot grant (registered)
//   done   out  [NUM_REQ] one-cycle completion pulse to the owner (registered)
//   busy   out  timer owned (RUN state)
//   tick   out  one-cycle pulse after each prescaler wrap, only while running
module timer_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned DUR_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DUR_W-1:0] dur,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     tick
);

  localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CandW = IdxW + 1;
  localparam int unsigned PsW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t           state_q;
  logic [IdxW-1:0]  rr_ptr_q;
  logic [IdxW-1:0]  owner_q;
  logic [PsW-1:0]   ps_q;
  logic [DUR_W-1:0] remaining_q;

  // Round-robin pick: first set request at or after rr_ptr_q, wrapping.
  logic             win_valid;
  logic [IdxW-1:0]  win_idx;
  logic [CandW-1:0] cand;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + CandW'(i);
      if (cand >= CandW'(NUM_REQ)) begin
        cand = cand - CandW'(NUM_REQ);
      end
      if (!win_valid && req[cand[IdxW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[IdxW-1:0];
      end
    end
  end

  logic [NUM_REQ-1:0] win_oh;
  logic [DUR_W-1:0]   win_dur;

  always_comb begin
    win_oh  = '0;
    win_dur = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IdxW'(i)) begin
        win_oh[i] = 1'b1;
        win_dur   = dur[i*DUR_W +: DUR_W];
      end
    end
  end

  logic [IdxW-1:0] next_ptr;
  assign next_ptr = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      ps_q        <= '0;
      remaining_q <= '0;
      grant       <= '0;
      done        <= '0;
      busy        <= 1'b0;
      tick        <= 1'b0;
    end else begin
      done <= '0;
      tick <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            grant       <= win_oh;
            owner_q     <= win_idx;
            remaining_q <= win_dur;
            ps_q        <= '0;
            busy        <= 1'b1;
            state_q     <= StRun;
          end
        end
        StRun: begin
`ifdef TIMER_ARBITER_ABORT_EN
          // grant still holds the owner's one-hot, so this tests req[owner].
          if ((req & grant) == '0) begin
            grant    <= '0;
            busy     <= 1'b0;
            rr_ptr_q <= next_ptr;
            state_q  <= StIdle;
          end else
`endif
          if (remaining_q == '0) begin
            done    <= grant;
            grant   <= '0;
            busy    <= 1'b0;
            state_q <= StDone;
          end else if (ps_q == PsW'(PRESCALE - 1)) begin
            ps_q        <= '0;
            remaining_q <= remaining_q - 1'b1;
            tick        <= 1'b1;
          end else begin
            ps_q <= ps_q + 1'b1;
          end
        end
        StDone: begin
          rr_ptr_q <= next_ptr;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter (NUM_REQ=4, PRESCALE=10, DUR_W=16): a vector table, hand
// sequences for the timing corners, and randomized traffic checked against a
// time-based reference model.
module tb_timer_arbiter;

  localparam int N = 4;
  localparam int P = 10;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N*W-1:0] dur;
  logic [N-1:0] grant, done;
  logic         busy, tick;

  timer_arbiter #(.NUM_REQ(N), .PRESCALE(P), .DUR_W(W)) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .dur  (dur),
    .grant(grant),
    .done (done),
    .busy (busy),
    .tick (tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 running, 2 done. m_k counts edges since the grant.
  // The owner finishes at edge dur*P+1 after the grant, and ticks at every multiple of P
  // up to dur*P.
  int m_phase = 0, m_owner = 0, m_ptr = 0, m_k = 0, m_dur = 0;

  task automatic model_update(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] du);
    if (r) begin
      m_phase = 0;
      m_ptr   = 0;
    end else if (m_phase == 0) begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (m_phase == 0 && rq[c]) begin
          m_owner = c;
          m_dur   = int'(du[c*W +: W]);
          m_k     = 0;
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      m_k++;
`ifdef TIMER_ARBITER_ABORT_EN
      if (!rq[m_owner]) begin
        m_phase = 0;
        m_ptr   = (m_owner + 1) % N;
      end else
`endif
      if (m_k == m_dur * P + 1) m_phase = 2;
    end else begin
      m_phase = 0;
      m_ptr   = (m_owner + 1) % N;
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int oh2idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    logic [N-1:0] eg, ed;
    logic eb, et;
    eg = (m_phase == 1) ? oh(m_owner) : '0;
    ed = (m_phase == 2) ? oh(m_owner) : '0;
    eb = (m_phase == 1);
    et = (m_phase == 1) && (m_k > 0) && (m_k % P == 0) && (m_k <= m_dur * P);
    chk("grant", int'(grant), int'(eg));
    chk("done",  int'(done),  int'(ed));
    chk("busy",  int'(busy),  int'(eb));
    chk("tick",  int'(tick),  int'(et));
  endtask

  // Drive inputs, take one rising edge, advance the model, settle past the edge.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] du);
    reset = r;
    req   = rq;
    dur   = du;
    @(posedge clk);
    model_update(r, rq, du);
    #1;
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] rq;
    logic [N-1:0] eg;
    logic [N-1:0] ed;
    logic         eb;
    logic         et;
  } vec_t;

  vec_t tbl[12];

  int done_k, tick_n, done_cnt, gcount, dcount;
  int tick_at[3];
  int gorder[5];
  int dedge[4];
  logic [N-1:0] prev_g, rq;
  logic [N*W-1:0] du;

  initial begin
    // All durations zero: each grant finishes one edge later and then returns to idle.
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'b0011, 4'b0001, 4'b0000, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 4'b0011, 4'b0000, 4'b0001, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'b0011, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'b0011, 4'b0010, 4'b0000, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 4'b0011, 4'b0000, 4'b0010, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};

    reset = 1'b1;
    req   = '0;
    dur   = '0;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].rq, '0);
      chk($sformatf("vec%0d.grant", i), int'(grant), int'(tbl[i].eg));
      chk($sformatf("vec%0d.done", i),  int'(done),  int'(tbl[i].ed));
      chk($sformatf("vec%0d.busy", i),  int'(busy),  int'(tbl[i].eb));
      chk($sformatf("vec%0d.tick", i),  int'(tick),  int'(tbl[i].et));
    end

    // Reset for 3 cycles, then 50 quiet idle cycles.
    for (int i = 0; i < 3; i++) step(1'b1, '0, '0);
    for (int i = 0; i < 50; i++) begin
      step(1'b0, '0, '0);
      chk_model();
    end

    // req[1] with dur=3: ticks at +10/+20/+30, done at +31 for exactly one cycle.
    du = '0;
    du[1*W +: W] = 16'd3;
    step(1'b0, 4'b0010, du);
    chk("single.grant", int'(grant), 2);
    done_k = -1; tick_n = 0; done_cnt = 0;
    for (int j = 1; j <= 60; j++) begin
      step(1'b0, (done_k < 0) ? 4'b0010 : 4'b0000, du);
      chk_model();
      if (tick) begin
        if (tick_n < 3) tick_at[tick_n] = j;
        tick_n++;
      end
      if (done[1]) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = j;
          chk("single.busy_with_done", int'(busy), 0);
        end
      end
    end
    chk("single.done_latency", done_k, 3 * P + 1);
    chk("single.done_cycles", done_cnt, 1);
    chk("single.tick_count", tick_n, 3);
    if (tick_n == 3) for (int t = 0; t < 3; t++) chk("single.tick_edge", tick_at[t], (t + 1) * P);

    // All four requesting, dur=1 each: round-robin order 0,1,2,3,0.
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
    du = {4{16'd1}};
    gcount = 0; dcount = 0; prev_g = '0;
    for (int j = 0; j < 80; j++) begin
      step(1'b0, 4'b1111, du);
      chk_model();
      if (prev_g == '0 && grant != '0 && gcount < 5) begin
        gorder[gcount] = oh2idx(grant);
        gcount++;
      end
      if (done != '0 && dcount < 4) begin
        dedge[dcount] = j;
        dcount++;
      end
      prev_g = grant;
    end
    chk("rr.grant_count", gcount, 5);
    chk("rr.done_count", dcount, 4);
    for (int i = 0; i < gcount; i++) chk($sformatf("rr.order%0d", i), gorder[i], i % N);
    // Run of dur*P+1 edges, one DONE edge, then the re-grant edge from idle.
    for (int i = 0; i + 1 < dcount; i++) chk("rr.done_spacing", dedge[i+1] - dedge[i], P + 3);

    // Reset in the middle of a dur=4 run must clear the pointer as well.
    step(1'b1, '0, '0);
    step(1'b0, 4'b0010, '0);
    step(1'b0, 4'b0010, '0);
    step(1'b0, 4'b0000, '0);
    step(1'b0, 4'b0000, '0);
    chk_model();
    du = {4{16'd4}};
    step(1'b0, 4'b0100, du);
    chk("rst.grant_before", int'(grant), 4);
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 4'b0100, du);
      chk_model();
    end
    step(1'b1, 4'b0100, du);
    chk("rst.grant", int'(grant), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    step(1'b1, 4'b0000, du);
    chk("rst.done2", int'(done), 0);
    step(1'b0, 4'b0101, du);
    chk("rst.winner0", int'(grant), 1);
    chk_model();

    // req[3], dur=5, dropped 20 edges into the run; dur changes after the grant are ignored.
    step(1'b1, '0, '0);
    du = '0;
    du[3*W +: W] = 16'd5;
    step(1'b0, 4'b1000, du);
    chk("drop.grant", int'(grant), 8);
    du = {4{16'd1}};
    done_k = -1;
    for (int j = 1; j <= 70; j++) begin
      step(1'b0, (j < 20) ? 4'b1000 : 4'b0000, du);
      chk_model();
      if (j == 20) begin
`ifdef TIMER_ARBITER_ABORT_EN
        chk("drop.grant_at_drop", int'(grant), 0);
        chk("drop.busy_at_drop", int'(busy), 0);
`else
        chk("drop.grant_at_drop", int'(grant), 8);
        chk("drop.busy_at_drop", int'(busy), 1);
`endif
      end
      if (done[3] && done_k < 0) done_k = j;
    end
`ifdef TIMER_ARBITER_ABORT_EN
    chk("drop.done_latency", done_k, -1);
`else
    chk("drop.done_latency", done_k, 5 * P + 1);
`endif

    // Randomized traffic against the model.
    rq = '0;
    du = '0;
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 7) == 0) rq = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) du[i*W +: W] = 16'($urandom_range(0, 3));
      step($urandom_range(0, 499) == 0, rq, du);
      chk_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
